// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: round-robin between instruction fetch and
// load/store. It holds one request on the controller port until completion.
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_valid,
    input  logic        ls_wr,
    input  logic [2:0]  ls_len,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_value,
    output logic        ls_done,
    output logic [31:0] ls_data,
    output logic        mc_waiting,
    output logic        mc_wr,
    output logic [2:0]  mc_len,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_value,
    input  logic        mc_ready,
    input  logic [31:0] mc_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        cancel_q, cancel_d;
    logic        mc_waiting_d, mc_wr_d;
    logic [2:0]  mc_len_d;
    logic [31:0] mc_addr_d, mc_value_d;
    logic        if_done_d, ls_done_d;
    logic [31:0] if_data_d, ls_data_d;

    logic if_ok, ls_ok, grant_ls, kill;

    // A flush only blocks requests whose results would be discarded;
    // stores must still reach memory.
    assign if_ok    = if_valid && !clear_in;
    assign ls_ok    = ls_valid && (ls_wr || !clear_in);
    assign grant_ls = ls_ok && (!if_ok || !last_q);
    assign kill     = clear_in && (!owner_q || !mc_wr);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cancel_d     = cancel_q;
        mc_waiting_d = mc_waiting;
        mc_wr_d      = mc_wr;
        mc_len_d     = mc_len;
        mc_addr_d    = mc_addr;
        mc_value_d   = mc_value;
        if_done_d    = if_done;
        ls_done_d    = ls_done;
        if_data_d    = if_data;
        ls_data_d    = ls_data;
        unique case (state_q)
            S_IDLE: begin
                cancel_d = 1'b0;
                if (if_ok || ls_ok) begin
                    owner_d      = grant_ls;
                    last_d       = grant_ls;
                    mc_waiting_d = 1'b1;
                    state_d      = S_WAIT;
                    if (grant_ls) begin
                        mc_wr_d    = ls_wr;
                        mc_len_d   = ls_len;
                        mc_addr_d  = ls_addr;
                        mc_value_d = ls_value;
                    end else begin
                        mc_wr_d    = 1'b0;
                        mc_len_d   = 3'b010;
                        mc_addr_d  = if_addr;
                        mc_value_d = 32'h0;
                    end
                end
            end
            S_WAIT: begin
                if (kill) cancel_d = 1'b1;
                if (mc_ready) begin
                    mc_waiting_d = 1'b0;
                    state_d      = S_DONE;
                    if (owner_q) ls_data_d = mc_result;
                    else         if_data_d = mc_result;
                    if_done_d = !owner_q && !(cancel_q || kill);
                    ls_done_d = owner_q && !(cancel_q || kill);
                end
            end
            S_DONE: begin
                if_done_d = 1'b0;
                ls_done_d = 1'b0;
                cancel_d  = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b0;
            cancel_q   <= 1'b0;
            mc_waiting <= 1'b0;
            mc_wr      <= 1'b0;
            mc_len     <= 3'b000;
            mc_addr    <= 32'h0;
            mc_value   <= 32'h0;
            if_done    <= 1'b0;
            ls_done    <= 1'b0;
            if_data    <= 32'h0;
            ls_data    <= 32'h0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cancel_q   <= cancel_d;
            mc_waiting <= mc_waiting_d;
            mc_wr      <= mc_wr_d;
            mc_len     <= mc_len_d;
            mc_addr    <= mc_addr_d;
            mc_value   <= mc_value_d;
            if_done    <= if_done_d;
            ls_done    <= ls_done_d;
            if_data    <= if_data_d;
            ls_data    <= ls_data_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, round-robin, flush, stall, reset.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        if_valid, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_valid, ls_wr, ls_done;
    logic [2:0]  ls_len;
    logic [31:0] ls_addr, ls_value, ls_data;
    logic        mc_waiting, mc_wr, mc_ready;
    logic [2:0]  mc_len;
    logic [31:0] mc_addr, mc_value, mc_result;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .clear_in(clear_in),
        .if_valid(if_valid), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data),
        .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_len(ls_len),
        .ls_addr(ls_addr), .ls_value(ls_value),
        .ls_done(ls_done), .ls_data(ls_data),
        .mc_waiting(mc_waiting), .mc_wr(mc_wr), .mc_len(mc_len),
        .mc_addr(mc_addr), .mc_value(mc_value),
        .mc_ready(mc_ready), .mc_result(mc_result)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        #1;
        chk1("rst_waiting", mc_waiting, 1'b0);
        chk("rst_addr", mc_addr, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_ls_data", ls_data, 32'h0);
        chk1("rst_if_done", if_done, 1'b0);
        chk1("rst_ls_done", ls_done, 1'b0);
        tick();
        rst_in = 1'b1;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
        if_valid = 1'b0; if_addr = 32'h0;
        ls_valid = 1'b0; ls_wr = 1'b0; ls_len = 3'b0;
        ls_addr = 32'h0; ls_value = 32'h0;
        mc_ready = 1'b0; mc_result = 32'h0;
        #2;
        do_reset();
        tick();

        // IF only
        if_valid = 1'b1; if_addr = 32'h100;
        tick();
        chk1("if_waiting", mc_waiting, 1'b1);
        chk("if_mc_addr", mc_addr, 32'h100);
        chk("if_mc_len", {29'h0, mc_len}, 32'h2);
        chk1("if_mc_wr", mc_wr, 1'b0);
        tick(); tick(); tick();
        chk1("if_still_waiting", mc_waiting, 1'b1);
        chk1("if_no_early_done", if_done, 1'b0);
        mc_ready = 1'b1; mc_result = 32'h00C00093;
        tick();
        chk1("if_done", if_done, 1'b1);
        chk("if_data", if_data, 32'h00C00093);
        chk1("if_done_waiting", mc_waiting, 1'b0);
        mc_ready = 1'b0; if_valid = 1'b0;
        tick();
        chk1("if_done_once", if_done, 1'b0);
        chk("if_data_hold", if_data, 32'h00C00093);

        // Conflict straight after reset: LS first
        do_reset();
        if_valid = 1'b1; if_addr = 32'h104;
        ls_valid = 1'b1; ls_wr = 1'b0; ls_len = 3'b100; ls_addr = 32'h200;
        tick();
        chk("cf_ls_addr", mc_addr, 32'h200);
        chk("cf_ls_len", {29'h0, mc_len}, 32'h4);
        mc_ready = 1'b1; mc_result = 32'hFFFFFF80;
        tick();
        chk1("cf_ls_done", ls_done, 1'b1);
        chk1("cf_if_not_done", if_done, 1'b0);
        chk("cf_ls_data", ls_data, 32'hFFFFFF80);
        mc_ready = 1'b0; ls_valid = 1'b0;
        tick();
        chk1("cf_ls_once", ls_done, 1'b0);
        tick();
        chk("cf_if_addr", mc_addr, 32'h104);
        mc_ready = 1'b1; mc_result = 32'h12345678;
        tick();
        chk1("cf_if_done", if_done, 1'b1);
        chk1("cf_ls_quiet", ls_done, 1'b0);
        chk("cf_if_data", if_data, 32'h12345678);
        mc_ready = 1'b0; if_valid = 1'b0;
        tick();
        chk1("cf_if_once", if_done, 1'b0);

        // Fairness
        if_valid = 1'b1; ls_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_addr", mc_addr, (i % 2 == 0) ? 32'h200 : 32'h104);
            mc_ready = 1'b1; mc_result = 32'(i);
            tick();
            chk1("rr_ls_done", ls_done, i % 2 == 0);
            chk1("rr_if_done", if_done, i % 2 != 0);
            mc_ready = 1'b0;
            if (i == 5) begin
                if_valid = 1'b0; ls_valid = 1'b0;
            end
            tick();
        end

        // Flush during fetch
        if_valid = 1'b1; if_addr = 32'h300;
        tick();
        clear_in = 1'b1; if_valid = 1'b0;
        tick();
        clear_in = 1'b0;
        chk1("clr_waiting", mc_waiting, 1'b1);
        chk("clr_addr", mc_addr, 32'h300);
        tick();
        chk1("clr_waiting2", mc_waiting, 1'b1);
        mc_ready = 1'b1; mc_result = 32'hAAAA5555;
        tick();
        chk1("clr_no_done", if_done, 1'b0);
        chk1("clr_release", mc_waiting, 1'b0);
        mc_ready = 1'b0;
        tick();
        chk1("clr_no_done2", if_done, 1'b0);
        tick();
        chk1("clr_idle", mc_waiting, 1'b0);

        // Flush and completion on the same edge
        if_valid = 1'b1; if_addr = 32'h304;
        tick();
        clear_in = 1'b1; mc_ready = 1'b1; if_valid = 1'b0;
        tick();
        clear_in = 1'b0; mc_ready = 1'b0;
        chk1("clr_same_no_done", if_done, 1'b0);
        tick();

        // Store survives flush, then stall in DONE
        ls_valid = 1'b1; ls_wr = 1'b1; ls_len = 3'b010;
        ls_addr = 32'h400; ls_value = 32'hDEADBEEF; clear_in = 1'b1;
        tick();
        chk("st_value", mc_value, 32'hDEADBEEF);
        chk1("st_wr", mc_wr, 1'b1);
        tick();
        clear_in = 1'b0;
        chk("st_value_hold", mc_value, 32'hDEADBEEF);
        mc_ready = 1'b1; mc_result = 32'h0;
        tick();
        chk1("st_done", ls_done, 1'b1);
        rdy_in = 1'b0; mc_ready = 1'b0; ls_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("stall_done", ls_done, 1'b1);
        end
        rdy_in = 1'b1;
        tick();
        chk1("stall_release", ls_done, 1'b0);

        // Flush in IDLE blocks a load grant
        ls_valid = 1'b1; ls_wr = 1'b0; clear_in = 1'b1;
        tick();
        chk1("clr_idle_load", mc_waiting, 1'b0);
        clear_in = 1'b0; ls_valid = 1'b0;
        tick();

        // Reset mid-transaction
        if_valid = 1'b1; if_addr = 32'h500;
        tick();
        chk1("rw_waiting", mc_waiting, 1'b1);
        #2;
        if_valid = 1'b0;
        do_reset();
        tick();
        chk1("rw_after", mc_waiting, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
